irq_ctrl_multi: RTL
===================

# irq_ctrl_multi

Parametrised interrupt controller for the HuC6280 core: the next generation of the three-source TIQ/IRQ1/IRQ2 controller, supporting up to eight sources. Each source can be level- or edge-sensitive at run time, edge events are latched as pending, and a fixed priority encoder gives the CPU one request line plus a source index. The block sits on the CPU's internal register bus behind the CECG_n chip-enable and drives the CPU's interrupt inputs.

## Interface
- NUM_IRQ, default 3: number of sources, 1..8; index NUM_IRQ-1 is highest priority (default mapping: 2=TIQ, 1=IRQ1, 0=IRQ2).
- EDGE_INIT, default 3'b100: reset value of the mode register; bit=1 means edge-sensitive.
- DIS_INIT, default 0: reset value of the disable register.

- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- RDY  in  1  CPU ready; register writes take effect only when high.
- re, we  in  1  bus read and write strobes.
- CECG_n  in  1  chip enable, active-low.
- addr  in  2  register select.
- dIn  in  8  write data.
- irq_n  in  NUM_IRQ  source request lines, active-low, synchronous to clk.
- int_ack  in  1  one-cycle pulse when the CPU takes the interrupt vector.
- dOut  out  8  read data, combinational.
- irq  out  NUM_IRQ  per-source enabled request.
- int_req  out  1  OR of irq.
- int_id  out  3  index of the highest-priority asserted irq bit, 0 when int_req=0.

## Operation
- A write strobe is RDY & ~CECG_n & we. A read selection is ~CECG_n & re.
- Registers are NUM_IRQ bits wide. Writes ignore dIn[7:NUM_IRQ]. Reads zero-extend.
  - addr 0, DIS: read/write. Bit=1 disables that source.
  - addr 1, STATUS: read returns the status vector. A write clears pend bits where dIn=1 (write-1-to-clear). Writing 0 has no effect.
  - addr 2, MODE: read/write. Bit=1 selects edge mode, bit=0 selects level mode.
  - addr 3, VECTOR: read returns {int_req, 4'b0, int_id}. Writes are ignored.
- Edge detect: prev is the registered irq_n. A fall on source i is prev[i] & ~irq_n[i]; in edge mode it sets pend[i].
- status[i] = MODE[i] ? pend[i] : ~irq_n[i].
- irq[i] = status[i] & ~DIS[i].
- pend bits set in level mode stay 0: pend only sets when MODE[i]=1.
- Writing MODE from 1 to 0 clears pend[i] on the same edge.
- On int_ack: if int_req=1, pend[int_id] clears, using the int_id of the same cycle. Level sources are unaffected; they drop when the source releases.
- Simultaneous set and clear of the same pend bit, from a W1C write or int_ack: set wins, so no edge is lost.
- dOut=0 whenever there is no read selection.
- Reset: DIS=DIS_INIT, MODE=EDGE_INIT, pend=0, prev=all ones (no spurious edge on the first cycle). Consequently irq, int_req and int_id are 0 unless a level-mode source is held low during reset.

## Timing
- Level source: irq, int_req and int_id follow irq_n combinationally, in the same cycle.
- Edge source: irq_n falls in cycle N, pend is set at the end of N, irq is visible in N+1.
- Register writes take effect at the clock edge ending the write cycle; outputs reflect them in the next cycle.
- Reads are combinational and reflect the current register state. A read in the same cycle as a write returns the old value.
- int_ack clears pend at the end of the ack cycle; int_req drops in the next cycle if nothing else is pending.

## Structure
- Package irq_ctrl_pkg: address constants ADDR_DIS=0, ADDR_STATUS=1, ADDR_MODE=2, ADDR_VECTOR=3, and MAX_IRQ=8.
- Sub-module irq_edge_latch, one instance per source:
  - holds prev and pend;
  - inputs: mode, set-clear controls;
  - output: status bit.
- The top level holds the DIS and MODE registers, the read mux and the priority encoder.

## Test plan
- Reset with defaults, all irq_n high: dOut at addr 0 = 0x00, addr 2 = 0x04, addr 3 = 0x00; int_req=0.
- Edge source 2: pulse irq_n[2] low for 1 cycle → irq[2]=1 from the next cycle and stays after the pulse; int_id=2. Then int_ack → int_req=0 one cycle later.
- Level source 0 low, then write DIS=0x01 → irq[0]=0 the cycle after the write; STATUS read still shows 0x01. Release irq_n[0] → STATUS=0x00.
- Sources 0 and 1 level-low together → int_id=1. Release 1 → int_id=0 in the same cycle.
- A new edge on source 2 in the same cycle as a STATUS W1C write of 0x04 (or an int_ack) → pend[2] stays 1.
- NUM_IRQ=8, EDGE_INIT=0xFF: edges on sources 7 and 3, ack twice → int_id reads 7 then 3, then int_req=0. A write with RDY=0 → no register change.

Source files
------------

// File: rtl/irq_ctrl_multi_pkg.sv
// Shared constants and helpers for the multi-source interrupt controller.
// Register map, source-count limit and the fixed-priority index function.
package irq_ctrl_pkg;

  localparam int MAX_IRQ = 8;

  localparam logic [1:0] ADDR_DIS    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_VECTOR = 2'd3;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic logic [2:0] highest_set(input logic [MAX_IRQ-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_multi_if.sv
// CPU register-bus port of the interrupt controller.
// The master (CPU side) drives strobes and write data; the slave returns read data.
interface irq_ctrl_multi_if;

  logic       RDY;
  logic       re;
  logic       we;
  logic       CECG_n;
  logic [1:0] addr;
  logic [7:0] dIn;
  logic [7:0] dOut;

  modport master (
    output RDY, re, we, CECG_n, addr, dIn,
    input  dOut
  );

  modport slave (
    input  RDY, re, we, CECG_n, addr, dIn,
    output dOut
  );

endinterface

// File: rtl/irq_ctrl_multi_edge_latch.sv
// Per-source falling-edge detector and pending latch.
// Produces the source status bit: pend in edge mode, the raw active-low level otherwise.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_n,
  input  logic mode,
  input  logic mode_clr,
  input  logic clr,
  output logic status
);

  logic prev_r;
  logic pend_r;
  logic set_s;

  assign set_s = mode & prev_r & ~irq_n;

  // Edge history and pending latch; a new edge beats W1C/ack so no event is lost,
  // while leaving edge mode always empties the latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= 1'b1;
      pend_r <= 1'b0;
    end else begin
      prev_r <= irq_n;
      if (mode_clr) begin
        pend_r <= 1'b0;
      end else if (set_s) begin
        pend_r <= 1'b1;
      end else if (clr) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  // Status selection between latched edge and live level.
  always_comb begin
    status = 1'b0;
    if (mode) begin
      status = pend_r;
    end else begin
      status = ~irq_n;
    end
  end

endmodule

// File: rtl/irq_ctrl_multi.sv
// Interrupt controller top: DIS/MODE registers, per-source edge latches,
// fixed-priority encoder (highest index wins) and the combinational read mux.
module irq_ctrl_multi
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ   = 3,
  parameter logic [NUM_IRQ-1:0] EDGE_INIT = 3'b100,
  parameter logic [NUM_IRQ-1:0] DIS_INIT  = {NUM_IRQ{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  irq_ctrl_multi_if.slave    bus,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic               int_ack,
  output logic [NUM_IRQ-1:0] irq,
  output logic               int_req,
  output logic [2:0]         int_id
);

  logic               wr_s;
  logic               rd_s;
  logic [NUM_IRQ-1:0] dis_r;
  logic [NUM_IRQ-1:0] mode_r;
  logic [NUM_IRQ-1:0] status_s;
  logic [NUM_IRQ-1:0] clr_s;
  logic [NUM_IRQ-1:0] mode_clr_s;
  logic [MAX_IRQ-1:0] irq_ext_s;
  logic [7:0]         rd_data_s;
  logic               unused_din_s;

  assign wr_s = bus.RDY & ~bus.CECG_n & bus.we;
  assign rd_s = ~bus.CECG_n & bus.re;
  assign unused_din_s = ^bus.dIn;

  // DIS and MODE registers; only the low NUM_IRQ data bits are stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      dis_r  <= DIS_INIT;
      mode_r <= EDGE_INIT;
    end else begin
      if (wr_s && (bus.addr == ADDR_DIS)) begin
        dis_r <= bus.dIn[NUM_IRQ-1:0];
      end else begin
        dis_r <= dis_r;
      end
      if (wr_s && (bus.addr == ADDR_MODE)) begin
        mode_r <= bus.dIn[NUM_IRQ-1:0];
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  // Pend clear controls: W1C on STATUS, ack of the currently reported source,
  // and a MODE write taking a source from edge back to level.
  always_comb begin
    clr_s      = {NUM_IRQ{1'b0}};
    mode_clr_s = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_s[i] = (wr_s && (bus.addr == ADDR_STATUS) && bus.dIn[i])
               || (int_ack && int_req && (int_id == 3'(i)));
      mode_clr_s[i] = wr_s && (bus.addr == ADDR_MODE) && mode_r[i] && !bus.dIn[i];
    end
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    irq_edge_latch u_latch (
      .clk      (clk),
      .reset    (reset),
      .irq_n    (irq_n[g]),
      .mode     (mode_r[g]),
      .mode_clr (mode_clr_s[g]),
      .clr      (clr_s[g]),
      .status   (status_s[g])
    );
  end

  // Request vector, global request and priority index.
  always_comb begin
    irq                     = status_s & ~dis_r;
    irq_ext_s               = {MAX_IRQ{1'b0}};
    irq_ext_s[NUM_IRQ-1:0]  = irq;
    int_req                 = |irq;
    int_id                  = highest_set(irq_ext_s);
  end

  // Read mux; zero-extended registers, all zeros when not selected.
  always_comb begin
    rd_data_s = 8'h00;
    if (rd_s) begin
      case (bus.addr)
        ADDR_DIS:    rd_data_s[NUM_IRQ-1:0] = dis_r;
        ADDR_STATUS: rd_data_s[NUM_IRQ-1:0] = status_s;
        ADDR_MODE:   rd_data_s[NUM_IRQ-1:0] = mode_r;
        ADDR_VECTOR: rd_data_s = {int_req, 4'b0000, int_id};
        default:     rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

  assign bus.dOut = rd_data_s;

endmodule
